// File: rtl/riscv_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV64 sequencer:
// state encoding, opcode/funct3 values, ALU codes and instruction classes.
package riscv_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      EXEC,
      MEM,
      WB,
      HALT
   } state_t;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_SD  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   localparam logic [2:0] F3_ADDSUB = 3'b000;
   localparam logic [2:0] F3_AND    = 3'b111;
   localparam logic [2:0] F3_OR     = 3'b110;
   localparam logic [2:0] F3_LDSD   = 3'b011;
   localparam logic [2:0] F3_BEQ    = 3'b000;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   // CLS_NONE marks an unsupported encoding
   typedef enum logic [2:0] {
      CLS_NONE,
      CLS_ADD,
      CLS_SUB,
      CLS_AND,
      CLS_OR,
      CLS_LD,
      CLS_SD,
      CLS_BEQ
   } iclass_t;

   function automatic iclass_t decode_class(input logic [6:0] op,
                                            input logic [2:0] f3,
                                            input logic       f7b5);
      iclass_t c;
      c = CLS_NONE;
      case (op)
         OP_R: begin
            case (f3)
               F3_ADDSUB: c = f7b5 ? CLS_SUB : CLS_ADD;
               F3_AND:    c = CLS_AND;
               F3_OR:     c = CLS_OR;
               default:   c = CLS_NONE;
            endcase
         end
         OP_LD:   if (f3 == F3_LDSD) c = CLS_LD;
         OP_SD:   if (f3 == F3_LDSD) c = CLS_SD;
         OP_BEQ:  if (f3 == F3_BEQ)  c = CLS_BEQ;
         default: c = CLS_NONE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational map from latched instruction class to ALU control code.
module alu_ctrl_dec
   import riscv_ctrl_pkg::*;
(
   input  logic [2:0] iclass,
   output logic [3:0] alu_control
);

   // branches compare by subtraction; loads/stores add base + offset
   always_comb begin
      alu_control = ALU_ADD;
      case (iclass)
         CLS_SUB, CLS_BEQ: alu_control = ALU_SUB;
         CLS_AND:          alu_control = ALU_AND;
         CLS_OR:           alu_control = ALU_OR;
         default:          alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer over one shared memory port.
// Optional build macro MEM_TIMEOUT_EN: bounds every memory wait to
// TIMEOUT_CYCLES cycles and halts when the bound is hit.
//
// state  | meaning
// IDLE   | stopped, waiting for run
// FETCH  | instruction read from PC address, waits for mem_ready
// DECODE | classify IR, illegal encodings go to HALT
// EXEC   | ALU operation; beq resolves and retires here
// MEM    | data access at ALU address (ld read / sd write)
// WB     | register-file write, retire
// HALT   | stopped until rst (illegal instruction or memory timeout)
module multicycle_seq_ctrl
   import riscv_ctrl_pkg::*;
#(
   parameter int CNT_W          = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic             funct7b5,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_read,
   output logic             mem_write,
   output logic             mem_sel_data,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_src,
   output logic             alu_src,
   output logic [3:0]       alu_control_signal,
   output logic             RegWrite,
   output logic             MemtoReg,
   output logic             halted,
   output logic             illegal_instr,
   output logic [CNT_W-1:0] retired
);

   state_t     state, state_nxt;
   iclass_t    cls_q, cls_dec;
   logic       retire;
   logic       timeout;
   logic [3:0] alu_dec;

   assign cls_dec = decode_class(opcode, funct3, funct7b5);

   alu_ctrl_dec u_alu_ctrl_dec (
      .iclass      (cls_q),
      .alu_control (alu_dec)
   );

   assign alu_control_signal = (state == EXEC) ? alu_dec : ALU_ADD;

`ifdef MEM_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

   logic          waiting;
   logic [TW-1:0] tmo_cnt;

   assign waiting = ((state == FETCH) || (state == MEM)) && !mem_ready;
   assign timeout = waiting && (tmo_cnt == '0);

   // down-counter of remaining wait cycles; reloads whenever not stalled
   always_ff @(posedge clk) begin
      if (rst || !waiting)
         tmo_cnt <= TMO_LOAD;
      else if (tmo_cnt != '0)
         tmo_cnt <= tmo_cnt - TW'(1);
   end
`else
   assign timeout = 1'b0;
`endif

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // class is latched once in DECODE and held through EXEC/MEM/WB
   always_ff @(posedge clk) begin
      if (rst)                  cls_q <= CLS_NONE;
      else if (state == DECODE) cls_q <= cls_dec;
   end

   // sticky illegal flag and retired-instruction counter
   always_ff @(posedge clk) begin
      if (rst) begin
         illegal_instr <= 1'b0;
         retired       <= '0;
      end else begin
         if (state == DECODE && cls_dec == CLS_NONE) illegal_instr <= 1'b1;
         if (retire) retired <= retired + CNT_W'(1);
      end
   end

   // next state and strobes
   always_comb begin
      state_nxt    = state;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      mem_sel_data = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_src       = 1'b0;
      alu_src      = 1'b0;
      RegWrite     = 1'b0;
      MemtoReg     = 1'b0;
      halted       = 1'b0;
      retire       = 1'b0;
      case (state)
         IDLE: if (run) state_nxt = FETCH;
         FETCH: begin
            mem_read = 1'b1;
            if (timeout) begin
               state_nxt = HALT;
            end else if (mem_ready) begin
               ir_write  = 1'b1;
               pc_write  = 1'b1;
               state_nxt = DECODE;
            end
         end
         DECODE: state_nxt = (cls_dec == CLS_NONE) ? HALT : EXEC;
         EXEC: begin
            case (cls_q)
               CLS_LD, CLS_SD: begin
                  alu_src   = 1'b1;
                  state_nxt = MEM;
               end
               CLS_BEQ: begin
                  pc_write  = zero;
                  pc_src    = zero;
                  retire    = 1'b1;
                  state_nxt = run ? FETCH : IDLE;
               end
               default: state_nxt = WB;
            endcase
         end
         MEM: begin
            mem_sel_data = 1'b1;
            if (cls_q == CLS_SD) mem_write = 1'b1;
            else                 mem_read  = 1'b1;
            if (timeout) begin
               state_nxt = HALT;
            end else if (mem_ready) begin
               if (cls_q == CLS_SD) begin
                  retire    = 1'b1;
                  state_nxt = run ? FETCH : IDLE;
               end else begin
                  state_nxt = WB;
               end
            end
         end
         WB: begin
            RegWrite  = 1'b1;
            MemtoReg  = (cls_q == CLS_LD);
            retire    = 1'b1;
            state_nxt = run ? FETCH : IDLE;
         end
         HALT:    halted = 1'b1;
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_multicycle_seq_ctrl.sv
// Scoreboard bench for multicycle_seq_ctrl. Each issued instruction pushes an
// expected per-instruction signature (cycle count and strobe counts derived
// from the instruction kind and the memory stalls chosen for it); a monitor
// accumulates the observed strobes and compares on every retire.
module tb_multicycle_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst, run, funct7b5, zero, mem_ready;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        mem_read, mem_write, mem_sel_data, ir_write, pc_write, pc_src;
   logic        alu_src, RegWrite, MemtoReg, halted, illegal_instr;
   logic [3:0]  alu_control_signal;
   logic [31:0] retired;
   logic [31:0] ir_word;

   assign opcode   = ir_word[6:0];
   assign funct3   = ir_word[14:12];
   assign funct7b5 = ir_word[30];

   always #5 clk = ~clk;

   multicycle_seq_ctrl #(.CNT_W(32), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct3(funct3),
      .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
      .mem_read(mem_read), .mem_write(mem_write), .mem_sel_data(mem_sel_data),
      .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
      .alu_src(alu_src), .alu_control_signal(alu_control_signal),
      .RegWrite(RegWrite), .MemtoReg(MemtoReg), .halted(halted),
      .illegal_instr(illegal_instr), .retired(retired)
   );

   typedef struct {
      int cyc; int rd; int wr; int sel; int irw; int pcw; int br;
      int rw; int m2r; int src; int nalu; int alu; longint ret;
   } sig_t;

   sig_t        exp_q[$];
   int          stall_q[$];
   logic [31:0] ir_q[$];
   logic        zero_q[$];
   int          checks = 0;
   int          errors = 0;
   longint      exp_ret = 0;
   int          fetches = 0;

   localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_OR = 3, K_LD = 4, K_SD = 5, K_BEQ = 6;

   task automatic chk(input string name, input longint act, input longint expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   function automatic logic [31:0] make_word(input int k);
      logic [31:0] w;
      w = $urandom;
      case (k)
         K_ADD: begin w[6:0] = 7'b0110011; w[14:12] = 3'b000; w[31:25] = 7'b0000000; end
         K_SUB: begin w[6:0] = 7'b0110011; w[14:12] = 3'b000; w[31:25] = 7'b0100000; end
         K_AND: begin w[6:0] = 7'b0110011; w[14:12] = 3'b111; w[31:25] = 7'b0000000; end
         K_OR:  begin w[6:0] = 7'b0110011; w[14:12] = 3'b110; w[31:25] = 7'b0000000; end
         K_LD:  begin w[6:0] = 7'b0000011; w[14:12] = 3'b011; end
         K_SD:  begin w[6:0] = 7'b0100011; w[14:12] = 3'b011; end
         default: begin w[6:0] = 7'b1100011; w[14:12] = 3'b000; end
      endcase
      return w;
   endfunction

   // expected signature from the instruction's kind, branch outcome and stalls
   task automatic issue(input logic [31:0] word, input int k, input logic z,
                        input int f, input int m);
      sig_t e;
      bit   is_mem, br;
      int   base, code;
      is_mem = (k == K_LD) || (k == K_SD);
      br     = (k == K_BEQ) && z;
      case (k)
         K_LD:    base = 5;
         K_BEQ:   base = 3;
         default: base = 4;
      endcase
      case (k)
         K_SUB, K_BEQ: code = 6;
         K_AND:        code = 0;
         K_OR:         code = 1;
         default:      code = 2;
      endcase
      e.cyc  = base + f + (is_mem ? m : 0);
      e.rd   = f + 1 + ((k == K_LD) ? m + 1 : 0);
      e.wr   = (k == K_SD) ? m + 1 : 0;
      e.sel  = is_mem ? m + 1 : 0;
      e.irw  = 1;
      e.pcw  = 1 + int'(br);
      e.br   = int'(br);
      e.rw   = (k <= K_LD) ? 1 : 0;
      e.m2r  = (k == K_LD) ? 1 : 0;
      e.src  = is_mem ? 1 : 0;
      e.nalu = (code != 2) ? 1 : 0;
      e.alu  = code;
      exp_ret++;
      e.ret  = exp_ret;
      ir_q.push_back(word);
      zero_q.push_back(z);
      stall_q.push_back(f);
      if (is_mem) stall_q.push_back(m);
      exp_q.push_back(e);
   endtask

   // memory model: each access waits its queued number of stall cycles
   initial begin
      bit active;
      int w;
      active = 0; w = 0;
      mem_ready = 1'b0; ir_word = '0; zero = 1'b0;
      forever begin
         @(negedge clk);
         if (rst || !(mem_read || mem_write)) begin
            active = 0;
            mem_ready = 1'b0;
         end else begin
            if (!active) begin
               active = 1;
               if (stall_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL mem_model: access with no stimulus queued (t=%0t)", $time);
                  w = 0;
               end else begin
                  w = stall_q.pop_front();
               end
            end else begin
               w--;
            end
            mem_ready = (w == 0);
            if (w == 0) begin
               active = 0;
               if (!mem_sel_data && ir_q.size() != 0) begin
                  ir_word = ir_q.pop_front();
                  zero    = zero_q.pop_front();
                  fetches++;
               end
            end
         end
      end
   end

   // monitor: accumulate strobes from fetch start, compare on each retire
   initial begin
      sig_t   a, e;
      bit     started;
      longint prev;
      started = 0; prev = 0;
      a = '{default: 0};
      forever begin
         @(negedge clk); #1;
         if (rst) begin
            started = 0;
            a = '{default: 0};
            prev = retired;
         end else begin
            if (retired != prev) begin
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL sb_unexpected_retire: retired=%0d", retired);
               end else begin
                  e = exp_q.pop_front();
                  chk("sb_cycles",    a.cyc,  e.cyc);
                  chk("sb_mem_read",  a.rd,   e.rd);
                  chk("sb_mem_write", a.wr,   e.wr);
                  chk("sb_sel_data",  a.sel,  e.sel);
                  chk("sb_ir_write",  a.irw,  e.irw);
                  chk("sb_pc_write",  a.pcw,  e.pcw);
                  chk("sb_branch",    a.br,   e.br);
                  chk("sb_regwrite",  a.rw,   e.rw);
                  chk("sb_memtoreg",  a.m2r,  e.m2r);
                  chk("sb_alu_src",   a.src,  e.src);
                  chk("sb_alu_cycles", a.nalu, e.nalu);
                  chk("sb_alu_code",  a.alu,  e.alu);
                  chk("sb_retired",   retired, e.ret);
               end
               prev = retired;
               started = 0;
               a = '{default: 0};
            end
            if (!started && mem_read && !mem_sel_data) begin
               started = 1;
               a.alu = 2;
            end
            if (started) begin
               a.cyc++;
               a.rd  += int'(mem_read);
               a.wr  += int'(mem_write);
               a.sel += int'(mem_sel_data);
               a.irw += int'(ir_write);
               a.pcw += int'(pc_write);
               a.br  += int'(pc_write && pc_src);
               a.rw  += int'(RegWrite);
               a.m2r += int'(MemtoReg);
               a.src += int'(alu_src);
               if (alu_control_signal != 4'b0010) begin
                  a.nalu++;
                  a.alu = int'(alu_control_signal);
               end
            end
         end
      end
   end

   // run everything queued, stop at the last fetch, then drain the scoreboard
   task automatic run_batch();
      int tgt, n, rd;
      tgt = fetches + ir_q.size();
      @(posedge clk); #2 run = 1'b1;
      n = 0;
      while (fetches != tgt && n < 20000) begin
         @(posedge clk); #2;
         n++;
      end
      run = 1'b0;
      chk("batch_fetches", fetches, tgt);
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk); #1;
         n++;
      end
      chk("drain_scoreboard", exp_q.size(), 0);
      rd = 0;
      repeat (5) begin
         @(negedge clk); #1;
         rd += int'(mem_read);
      end
      chk("stop_at_fetch", rd, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1; run = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      exp_ret = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, nrd;
      rst = 1'b1; run = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      repeat (3) begin
         @(negedge clk); #1;
         chk("reset_strobes", {mem_read, mem_write, mem_sel_data, ir_write, pc_write,
                               pc_src, alu_src, RegWrite, MemtoReg, halted, illegal_instr}, 0);
         chk("reset_retired", retired, 0);
      end

      // reset while a load sits in MEM: strobes drop at once, nothing retires
      ir_q.push_back(make_word(K_LD)); zero_q.push_back(1'b0);
      stall_q.push_back(0); stall_q.push_back(12);
      @(posedge clk); #2 run = 1'b1;
      n = 0;
      do begin
         @(negedge clk); #1;
         n++;
      end while (!(mem_read && mem_sel_data) && n < 30);
      chk("ld_mem_latency", n, 5);
      rst = 1'b1; run = 1'b0;
      @(posedge clk); #1;
      chk("rst_mid_strobes", {mem_read, mem_write, mem_sel_data}, 0);
      chk("rst_mid_retired", retired, 0);
      @(posedge clk); #2 rst = 1'b0;

      // directed instructions
      issue(32'h00000033, K_ADD, 1'b0, 0, 0);
      issue(32'h40000033, K_SUB, 1'b0, 0, 0);
      issue(32'h0041B423, K_SD,  1'b0, 0, 3);
      issue(32'h00628A63, K_BEQ, 1'b1, 0, 0);
      issue(32'h00628A63, K_BEQ, 1'b0, 0, 0);
      issue(make_word(K_LD),  K_LD,  1'b1, 2, 1);
      issue(make_word(K_AND), K_AND, 1'b1, 1, 0);
      issue(make_word(K_OR),  K_OR,  1'b0, 0, 0);
      run_batch();

      // randomized stream
      for (int i = 0; i < 60; i++) begin
         int k, f, m;
         k = $urandom_range(0, 6);
         f = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4);
         m = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4);
         issue(make_word(k), k, 1'($urandom_range(0, 1)), f, m);
      end
      run_batch();

      // illegal encoding: HALT after DECODE, run ignored, rst clears
      ir_q.push_back(32'hFFFFFFFF); zero_q.push_back(1'b0); stall_q.push_back(0);
      @(posedge clk); #2 run = 1'b1;
      n = 0;
      do begin
         @(negedge clk); #1;
         n++;
      end while (!halted && n < 20);
      chk("halt_latency", n, 4);
      chk("illegal_flag", illegal_instr, 1);
      repeat (6) begin
         @(posedge clk); #2 run = 1'($urandom_range(0, 1));
         @(negedge clk); #1;
         chk("halt_sticky", {halted, illegal_instr, mem_read, mem_write}, 4'b1100);
         chk("halt_alu_code", alu_control_signal, 4'b0010);
         chk("halt_retired", retired, exp_ret);
      end
      do_reset();
      @(negedge clk); #1;
      chk("halt_cleared", {halted, illegal_instr}, 0);
      chk("halt_rst_retired", retired, 0);

`ifdef MEM_TIMEOUT_EN
      ir_q.push_back(make_word(K_ADD)); zero_q.push_back(1'b0); stall_q.push_back(1000);
      @(posedge clk); #2 run = 1'b1;
      n = 0; nrd = 0;
      do begin
         @(negedge clk); #1;
         nrd += int'(mem_read);
         n++;
      end while (!halted && n < 60);
      chk("timeout_waits", nrd, 16);
      chk("timeout_illegal", illegal_instr, 0);
      do_reset();
      ir_q.delete(); zero_q.delete(); stall_q.delete();
`else
      nrd = 0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
